mac_t: RTL

MII transmit MAC; the transmit-side counterpart of mac_r. Pops one frame descriptor from a pointer FIFO and the frame bytes from a data FIFO, then drives tx_en/tx_d nibble-wise: preamble, SFD, data, optional pad, then a generated IEEE 802.3 FCS. Runs entirely in the MII tx clock domain. Upstream FIFOs are store-and-forward: a descriptor is written only after all its bytes are in the data FIFO.

---
 rtl/mac_t_pkg.sv | 44 ++++
 rtl/mac_t_crc32_nibble.sv | 25 ++
 rtl/mac_t.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_t_pkg.sv
// Shared definitions for the MII transmit MAC (mac_t).
// Holds the state encoding, line constants, descriptor field position and
// the per-nibble CRC-32 step used by crc32_nibble.
package mac_t_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LOAD = 4'd1,
        ST_PRE  = 4'd2,
        ST_SFD  = 4'd3,
        ST_DATA = 4'd4,
        ST_PAD  = 4'd5,
        ST_FCS  = 4'd6,
        ST_IFG  = 4'd7,
        ST_DROP = 4'd8
    } mac_t_state_e;

    localparam logic [3:0]  SFD_NIBBLE  = 4'hD;
    localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Frame length field inside the 16-bit descriptor
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 10;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    // One reflected CRC-32 step over a nibble, bit 0 of the nibble first
    function automatic logic [31:0] crc32_nibble_next(input logic [31:0] crc,
                                                      input logic [3:0]  d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_t_crc32_nibble.sv
// Nibble-serial CRC-32 (IEEE 802.3, reflected) for the transmit MAC.
// crc is the raw running register; the caller complements it for the FCS.
module crc32_nibble
    import mac_t_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  d,
    output logic [31:0] crc
);

    // Running CRC register: cleared on reset, preset on init, stepped on en
    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= '0;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_nibble_next(crc, d);
        end
    end

endmodule

// File: rtl/mac_t.sv
// MII transmit MAC. Pops a frame descriptor and its bytes from
// store-and-forward FIFOs and sends preamble, SFD, data, optional pad and
// the FCS one nibble per clock.
// Build option: define MAC_T_PAD_EN to zero-pad short frames to MIN_LEN.
//
// FIFO handshake: ptr_fifo_rd / data_fifo_rd are one-cycle pop strobes.
// The popped word appears on *_dout in the cycle after the strobe and is
// held until the next pop. A descriptor is popped only while ptr_fifo_empty
// is low; data bytes are popped without an empty check because a descriptor
// is only visible once all of its bytes are already in the data FIFO.
module mac_t
    import mac_t_pkg::*;
#(
    parameter int PRE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24,
    parameter int MIN_LEN     = 60,
    parameter int MAX_LEN     = 1514
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  ptr_fifo_dout,
    input  logic         ptr_fifo_empty,
    output logic         ptr_fifo_rd,
    input  logic [7:0]   data_fifo_dout,
    output logic         data_fifo_rd,
    output logic         tx_en,
    output logic [3:0]   tx_d,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         tx_drop,
    output mac_t_state_e dbg_state
);

    localparam logic [LEN_W-1:0] PRE_CNT = LEN_W'(PRE_NIBBLES);
    localparam logic [LEN_W-1:0] IFG_CNT = LEN_W'(IFG_NIBBLES);
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
`ifdef MAC_T_PAD_EN
    localparam logic [LEN_W-1:0] MIN_CNT = LEN_W'(MIN_LEN);
`else
    localparam logic [LEN_W-1:0] unused_min_cnt = LEN_W'(MIN_LEN);
`endif

    mac_t_state_e     state;
    logic             load_wait;   // first LOAD cycle: descriptor not yet on dout
    logic             phase;       // 0: low nibble of a byte, 1: high nibble
    logic [LEN_W-1:0] cnt;         // preamble / FCS / IFG / drop counter
    logic [LEN_W-1:0] len;         // latched frame length
    logic [LEN_W-1:0] byte_cnt;    // bytes fetched or padded so far
    logic [3:0]       tx_d_q;      // registered nibble for PRE/SFD/high/pad
    logic [LEN_W-1:0] desc_len;
    logic [31:0]      crc;
    logic [3:0]       fcs_nib;
    logic             crc_init;
    logic             crc_en;
    logic [4:0]       unused_desc;

    assign desc_len    = ptr_fifo_dout[LEN_MSB:LEN_LSB];
    assign unused_desc = ptr_fifo_dout[15:11];
    assign dbg_state   = state;

    // CRC preset during SFD, then stepped with every data/pad nibble on the wire
    assign crc_init = (state == ST_SFD);
    assign crc_en   = (state == ST_DATA) || (state == ST_PAD);
    assign fcs_nib  = ~crc[{cnt[2:0], 2'b00} +: 4];

    crc32_nibble u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .d     (tx_d),
        .crc   (crc)
    );

    // Nibble select: the low nibble of each byte bypasses straight from the
    // FIFO (it only arrives this cycle), the FCS comes from the settled CRC
    always_comb begin
        tx_d = tx_d_q;
        if (state == ST_DATA && !phase) begin
            tx_d = data_fifo_dout[3:0];
        end else if (state == ST_FCS) begin
            tx_d = fcs_nib;
        end
    end

    // Transmit FSM with registered strobes and enables
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            load_wait    <= 1'b0;
            phase        <= 1'b0;
            cnt          <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            tx_d_q       <= '0;
            ptr_fifo_rd  <= 1'b0;
            data_fifo_rd <= 1'b0;
            tx_en        <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            ptr_fifo_rd  <= 1'b0;
            data_fifo_rd <= 1'b0;
            tx_done      <= 1'b0;
            tx_drop      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!ptr_fifo_empty) begin
                        ptr_fifo_rd <= 1'b1;
                        tx_busy     <= 1'b1;
                        load_wait   <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_wait) begin
                        load_wait <= 1'b0;
                    end else begin
                        len <= desc_len;
                        if (desc_len == '0) begin
                            tx_drop <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= ST_IDLE;
                        end else if (desc_len > MAX_CNT) begin
                            tx_drop      <= 1'b1;
                            data_fifo_rd <= 1'b1;
                            cnt          <= LEN_W'(1);
                            state        <= ST_DROP;
                        end else begin
                            tx_en  <= 1'b1;
                            tx_d_q <= PRE_NIBBLE;
                            cnt    <= LEN_W'(1);
                            state  <= ST_PRE;
                        end
                    end
                end
                ST_PRE: begin
                    if (cnt < PRE_CNT) begin
                        cnt <= cnt + LEN_W'(1);
                    end else begin
                        tx_d_q       <= SFD_NIBBLE;
                        data_fifo_rd <= 1'b1;
                        state        <= ST_SFD;
                    end
                end
                ST_SFD: begin
                    phase    <= 1'b0;
                    byte_cnt <= '0;
                    state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (!phase) begin
                        tx_d_q       <= data_fifo_dout[7:4];
                        phase        <= 1'b1;
                        byte_cnt     <= byte_cnt + LEN_W'(1);
                        data_fifo_rd <= (byte_cnt + LEN_W'(1)) < len;
                    end else begin
                        phase <= 1'b0;
                        if (byte_cnt == len) begin
                            tx_d_q <= '0;
                            cnt    <= '0;
`ifdef MAC_T_PAD_EN
                            if (byte_cnt < MIN_CNT) begin
                                state <= ST_PAD;
                            end else begin
                                state <= ST_FCS;
                            end
`else
                            state <= ST_FCS;
`endif
                        end
                    end
                end
`ifdef MAC_T_PAD_EN
                ST_PAD: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        byte_cnt <= byte_cnt + LEN_W'(1);
                        if ((byte_cnt + LEN_W'(1)) >= MIN_CNT) begin
                            cnt   <= '0;
                            state <= ST_FCS;
                        end
                    end
                end
`endif
                ST_FCS: begin
                    cnt <= cnt + LEN_W'(1);
                    if (cnt == LEN_W'(6)) begin
                        tx_done <= 1'b1;
                    end
                    if (cnt == LEN_W'(7)) begin
                        tx_en  <= 1'b0;
                        tx_d_q <= '0;
                        cnt    <= LEN_W'(1);
                        state  <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (cnt < IFG_CNT) begin
                        cnt <= cnt + LEN_W'(1);
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (cnt < len) begin
                        data_fifo_rd <= 1'b1;
                        cnt          <= cnt + LEN_W'(1);
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    tx_en   <= 1'b0;
                    tx_d_q  <= '0;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
